// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: in-order pipeline results take priority,
// long-latency results queue in a FIFO and drain via a starvation-forced stall.
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wreg,
  input  logic [4:0]  pipe_wd,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_wd,
  input  logic [31:0] lu_wdata,
  input  logic        issue_valid,
  input  logic [4:0]  issue_wd,
  output logic [31:0] busy,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  wd;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt, starve_inc;
  logic            push, pop, pipe_sel, fifo_nz, starve_hit;
  logic [31:0]     busy_nxt;

  // ready depends only on registered count, so a pop never raises it combinationally
  assign lu_ready   = (count != CW'(DEPTH)) && rst;
  assign push       = lu_valid && lu_ready && (lu_wd != 5'd0);
  assign fifo_nz    = (count != '0);
  assign pipe_sel   = !pipe_stall && pipe_wreg && (pipe_wd != 5'd0);
  assign pop        = !pipe_sel && fifo_nz;
  assign head       = mem[rd_ptr];
  assign starve_inc = starve_cnt + SW'(1);
  assign starve_hit = pipe_sel && fifo_nz && (starve_inc == SW'(STARVE_MAX));

  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[head.wd] = 1'b0;
    // issue after clear so a same-cycle set wins
    if (issue_valid && issue_wd != 5'd0) busy_nxt[issue_wd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{wd: lu_wd, data: lu_wdata};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
      busy       <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      pipe_stall <= starve_hit;
      if (pop || !fifo_nz || starve_hit) starve_cnt <= '0;
      else if (pipe_sel)                 starve_cnt <= starve_inc;

      busy <= busy_nxt;

      if (pipe_sel) begin
        we    <= 1'b1;
        waddr <= pipe_wd;
        wdata <= pipe_wdata;
      end else if (pop) begin
        we    <= 1'b1;
        waddr <= head.wd;
        wdata <= head.data;
      end else begin
        we    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one task per scenario, inline checks, one summary line.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wreg;
  logic [4:0]  pipe_wd;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wd;
  logic [31:0] lu_wdata;
  logic        issue_valid;
  logic [4:0]  issue_wd;
  logic [31:0] busy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wreg(pipe_wreg), .pipe_wd(pipe_wd), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wd(lu_wd), .lu_wdata(lu_wdata),
    .issue_valid(issue_valid), .issue_wd(issue_wd),
    .busy(busy), .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  // advance one edge; outputs then reflect that edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wreg = 0; pipe_wd = 0; pipe_wdata = 0;
    lu_valid = 0; lu_wd = 0; lu_wdata = 0;
    issue_valid = 0; issue_wd = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    pipe_wreg = 1; pipe_wd = 5'd3; pipe_wdata = 32'hAAAA0003;
    lu_valid = 1; lu_wd = 5'd4; lu_wdata = 32'hBBBB0004;
    issue_valid = 1; issue_wd = 5'd6;
    step(); step();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", we); end
    checks++; if (waddr !== 5'd0) begin failures++; $display("FAIL rst_waddr got=%0d exp=0", waddr); end
    checks++; if (wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", wdata); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL rst_busy got=%h exp=0", busy); end
    checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL rst_lu_ready got=%0b exp=0", lu_ready); end
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", pipe_stall); end
    idle_inputs();
    rst = 1;
    #1;
    checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL rel_lu_ready got=%0b exp=1", lu_ready); end
    step();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL rel_we got=%0b exp=0", we); end
  endtask

  task automatic test_pipe_write();
    pipe_wreg = 1; pipe_wd = 5'd5; pipe_wdata = 32'hDEADBEEF;
    step();
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL pipe_we got=%0b exp=1", we); end
    checks++; if (waddr !== 5'd5) begin failures++; $display("FAIL pipe_waddr got=%0d exp=5", waddr); end
    checks++; if (wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL pipe_wdata got=%h exp=deadbeef", wdata); end
    pipe_wd = 5'd0; pipe_wdata = 32'h11111111;
    step();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL pipe_r0_we got=%0b exp=0", we); end
    checks++; if (wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL pipe_hold_wdata got=%h exp=deadbeef", wdata); end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_wd = 5'd7;
    step();
    issue_valid = 0;
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL sb_set got=%h exp=00000080", busy); end
    lu_valid = 1; lu_wd = 5'd7; lu_wdata = 32'h12345678;
    #1;
    checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL sb_ready got=%0b exp=1", lu_ready); end
    step();
    lu_valid = 0;
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL sb_early_we got=%0b exp=0", we); end
    checks++; if (busy[7] !== 1'b1) begin failures++; $display("FAIL sb_still_busy got=%0b exp=1", busy[7]); end
    step();
    checks++; if (we !== 1'b1 || waddr !== 5'd7) begin failures++; $display("FAIL sb_pop got we=%0b waddr=%0d exp we=1 waddr=7", we, waddr); end
    checks++; if (wdata !== 32'h12345678) begin failures++; $display("FAIL sb_wdata got=%h exp=12345678", wdata); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL sb_clear got=%h exp=0", busy); end
    idle_inputs();
    step();
  endtask

  task automatic test_fifo_full();
    pipe_wreg = 1; pipe_wd = 5'd1; pipe_wdata = 32'd100;
    lu_valid = 1; lu_wd = 5'd10; lu_wdata = 32'hA0A0A0A0;
    step();
    lu_wd = 5'd11; lu_wdata = 32'hB1B1B1B1; pipe_wdata = 32'd101;
    #1;
    checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL full_ready1 got=%0b exp=1", lu_ready); end
    step();
    lu_valid = 0;
    checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL full_ready0 got=%0b exp=0", lu_ready); end
    checks++; if (we !== 1'b1 || waddr !== 5'd1 || wdata !== 32'd101) begin failures++; $display("FAIL full_pipe got we=%0b waddr=%0d wdata=%0d exp 1/1/101", we, waddr, wdata); end
    pipe_wreg = 0;
    step();
    checks++; if (we !== 1'b1 || waddr !== 5'd10 || wdata !== 32'hA0A0A0A0) begin failures++; $display("FAIL drain0 got we=%0b waddr=%0d wdata=%h exp 1/10/a0a0a0a0", we, waddr, wdata); end
    step();
    checks++; if (we !== 1'b1 || waddr !== 5'd11 || wdata !== 32'hB1B1B1B1) begin failures++; $display("FAIL drain1 got we=%0b waddr=%0d wdata=%h exp 1/11/b1b1b1b1", we, waddr, wdata); end
    step();
    checks++; if (we !== 1'b0 || lu_ready !== 1'b1) begin failures++; $display("FAIL drained got we=%0b ready=%0b exp 0/1", we, lu_ready); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    pipe_wreg = 1; pipe_wd = 5'd2; pipe_wdata = 32'd200;
    lu_valid = 1; lu_wd = 5'd12; lu_wdata = 32'hC0C0C0C0;
    step();
    lu_valid = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (pipe_stall !== 1'b0 || waddr !== 5'd2) begin failures++; $display("FAIL starve_block%0d got stall=%0b waddr=%0d exp 0/2", k, pipe_stall, waddr); end
    end
    step();
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL starve_stall got=%0b exp=1", pipe_stall); end
    pipe_wd = 5'd3; pipe_wdata = 32'h55555555;
    step();
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL starve_one_cycle got=%0b exp=0", pipe_stall); end
    checks++; if (we !== 1'b1 || waddr !== 5'd12 || wdata !== 32'hC0C0C0C0) begin failures++; $display("FAIL starve_pop got we=%0b waddr=%0d wdata=%h exp 1/12/c0c0c0c0", we, waddr, wdata); end
    pipe_wd = 5'd2; pipe_wdata = 32'd201;
    step();
    checks++; if (waddr !== 5'd2 || wdata !== 32'd201) begin failures++; $display("FAIL starve_resume got waddr=%0d wdata=%0d exp 2/201", waddr, wdata); end
    idle_inputs();
    step();
  endtask

  task automatic test_simultaneous();
    issue_valid = 1; issue_wd = 5'd9;
    lu_valid = 1; lu_wd = 5'd9; lu_wdata = 32'h99999999;
    step();
    lu_valid = 0;
    step();
    checks++; if (we !== 1'b1 || waddr !== 5'd9 || busy[9] !== 1'b1) begin failures++; $display("FAIL sim_set_wins got we=%0b waddr=%0d busy9=%0b exp 1/9/1", we, waddr, busy[9]); end
    issue_valid = 0;
    step();
    checks++; if (busy !== 32'h0000_0200) begin failures++; $display("FAIL sim_busy_hold got=%h exp=00000200", busy); end
  endtask

  task automatic test_reset_mid_drain();
    pipe_wreg = 1; pipe_wd = 5'd1; pipe_wdata = 32'd300;
    lu_valid = 1; lu_wd = 5'd13; lu_wdata = 32'hD0D0D0D0;
    step();
    lu_wd = 5'd14; lu_wdata = 32'hE0E0E0E0;
    step();
    lu_valid = 0;
    checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL mid_full got=%0b exp=0", lu_ready); end
    rst = 0; pipe_wreg = 0;
    step();
    checks++; if (we !== 1'b0 || busy !== 32'd0 || lu_ready !== 1'b0) begin failures++; $display("FAIL mid_rst got we=%0b busy=%h ready=%0b exp 0/0/0", we, busy, lu_ready); end
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (we !== 1'b0 || lu_ready !== 1'b1) begin failures++; $display("FAIL mid_after%0d got we=%0b ready=%0b exp 0/1", k, we, lu_ready); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    test_reset();
    test_pipe_write();
    test_scoreboard();
    test_fifo_full();
    test_starvation();
    test_simultaneous();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that drives the register file write port (`we`/`waddr`/`wdata`) from two producers. The first is the in-order pipeline result. The second is a long-latency unit (divider/load unit) with a valid/ready handshake. Long-latency results queue in a small FIFO, and a 32-bit scoreboard tracks registers with an outstanding long-latency write. A starvation counter forces a one-cycle pipeline stall so queued results always drain.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries for long-latency results. Power of two, 2..8.
- `STARVE_MAX`, 4: consecutive blocked cycles of a non-empty FIFO before a stall is forced.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `pipe_wreg`, in, 1: pipeline result wants a write this cycle.
- `pipe_wd`, in, 5: pipeline destination register.
- `pipe_wdata`, in, 32: pipeline result data.
- `pipe_stall`, out, 1: registered. When high, pipe inputs are ignored this cycle and upstream must hold them.
- `lu_valid`, in, 1: long-latency result offered.
- `lu_ready`, out, 1: combinational. Equals `(count != DEPTH) && rst`.
- `lu_wd`, in, 5: long-latency destination register.
- `lu_wdata`, in, 32: long-latency result data.
- `issue_valid`, in, 1: a long-latency op issues this cycle.
- `issue_wd`, in, 5: destination of the issuing op.
- `busy`, out, 32: scoreboard bitmap. Bit i set means register i has an outstanding long-latency write. Bit 0 is always 0.
- `we`, out, 1: registered write enable to the register file.
- `waddr`, out, 5: registered write address.
- `wdata`, out, 32: registered write data.

## Operation
- **FIFO.**
  - Circular buffer with `rd_ptr`, `wr_ptr` (log2 DEPTH bits, wrapping) and `count` (0..DEPTH).
  - Push when `lu_valid && lu_ready`.
  - Push with `lu_wd == 0` is accepted and discarded: no entry is stored and `count` is unchanged.
- **Source select, evaluated each cycle (priority order):**
  - If `pipe_stall` is low and `pipe_wreg` is high and `pipe_wd != 0`: the pipeline source wins.
  - Otherwise, if `count != 0`: the FIFO head is popped.
  - Otherwise: no write.
  - A pipeline write with `pipe_wd == 0` is dropped and does not block the FIFO.
- **Output register.**
  - When a source is selected: `we <= 1`, with `waddr`/`wdata` loaded from that source.
  - When nothing is selected: `we <= 0`, and `waddr`/`wdata` hold their previous values.
- **Simultaneous push and pop.**
  - `count` is unchanged.
  - Both pointers advance.
  - The pushed entry is never popped in its own push cycle.
- **Scoreboard.**
  - `issue_valid && issue_wd != 0` sets `busy[issue_wd]`.
  - A FIFO pop clears `busy[head.wd]`.
  - Pipeline writes never touch `busy`.
  - Set and clear of the same bit in the same cycle: set wins.
- **Starvation.**
  - `starve_cnt` increments on each cycle where `count != 0` and the pipeline source won.
  - It resets to 0 on any FIFO pop or when `count == 0`.
  - When `starve_cnt` reaches `STARVE_MAX`, `pipe_stall <= 1` for exactly one cycle and `starve_cnt <= 0`.
  - During that stall cycle the FIFO head pops unconditionally.
- **Reset (rst low at a clock edge).**
  - Outputs: `we=0`, `waddr=0`, `wdata=0`, `busy=0`, `pipe_stall=0`.
  - Internal state: `count=0`, `rd_ptr=0`, `wr_ptr=0`, `starve_cnt=0`.
  - FIFO contents are discarded. A reset mid-operation drops all queued results.
  - `lu_ready` is 0 while `rst` is low.

## Timing
- **Pipeline latency.** A pipeline result sampled at edge N appears on `we`/`waddr`/`wdata` after edge N, i.e. during cycle N+1.
- **Long-latency latency.**
  - A handshake at edge N stores the entry. It is poppable in cycle N+1, and `we` is high in cycle N+2 at the earliest.
  - `busy` clears at the same edge that loads the output register.
- **Back-pressure.**
  - `lu_ready` falls in the same cycle `count` reaches DEPTH.
  - A pop in a cycle with `count == DEPTH` raises `lu_ready` in the next cycle only (no combinational pop-to-ready path).
- **Stall timing.**
  - `pipe_stall` is high for one cycle, starting the cycle after `starve_cnt` reaches `STARVE_MAX`.
  - Worst-case wait for a queued head is therefore `STARVE_MAX+1` cycles.
- **Throughput.**
  - At most one register-file write per cycle.
  - The long-latency path sustains one result per cycle while the pipeline is idle.

## Test plan
- **Reset values.** Hold rst=0 for 2 cycles with all inputs active. Required: `we=0`, `waddr=0`, `wdata=0`, `busy=0`, `lu_ready=0`, `pipe_stall=0`. After release, `lu_ready=1`.
- **Pipeline write.** `pipe_wreg=1`, `pipe_wd=5`, `pipe_wdata=32'hDEADBEEF` at edge N. Required in cycle N+1: `we=1`, `waddr=5`, `wdata=32'hDEADBEEF`. `pipe_wd=0` instead gives `we=0`.
- **Scoreboard set and clear.** `issue_wd=7` sets `busy[7]`. Then `lu_wd=7`, `lu_wdata=32'h12345678` is handshaken with the pipeline idle. Required: `we=1`, `waddr=7` two cycles after the handshake, and `busy[7]=0` in that same cycle.
- **FIFO full.** With the pipeline writing every cycle, push 2 results. Required: `lu_ready=0` once `count=2`. When pipeline writes stop, both results drain in order on consecutive cycles, then `lu_ready=1`.
- **Starvation.** Queue one result and keep `pipe_wreg=1` with a nonzero `pipe_wd` continuously. Required: `pipe_stall=1` for exactly one cycle after 4 blocked cycles. The queued result writes in the cycle following the stall; the pipeline input presented during the stall is not written.
- **Simultaneous events and reset mid-drain.**
  - Same-cycle issue and pop of register 9: `busy[9]` stays 1.
  - Reset asserted while `count=2`: `count=0`, and no `we` pulse after reset release.
